fen_board_loader: RTL and testbench
===================================

Name: fen_board_loader

Overview:
- Sits directly downstream of fen_decode and consumes its per-square piece stream and position metadata.
- Assembles a complete, validated 64-square board in a double-buffered store.
- Publishes the board atomically, together with side-to-move, castling, en-passant and move counters, to the move-generation logic.
- A malformed frame never disturbs the board already published.

Parameters:
- SQUARES, 64, squares expected per frame.
- CHECK_KINGS, 1, when 1 require exactly one white king and one black king per frame.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  one square piece code present on in_pdata
- in_pdata  input  4  piece code: 0 empty; bits[2:0] type 1=P 2=N 3=B 4=R 5=Q 6=K; bit3 set = black
- in_turn  input  1  side to move, 0 white, 1 black
- in_castle  input  4  castling rights KQkq
- in_ep  input  3  en-passant file
- in_hmcount  input  16  halfmove clock
- in_fmcount  input  16  fullmove number
- in_frame_end  input  1  end of FEN frame; metadata inputs are stable this cycle
- rd_addr  input  6  board read address, 0=a8 .. 7=h8, 8=a7 .. 63=h1 (FEN order)
- rd_data  output  4  piece code at rd_addr from the published bank, registered
- board_valid  output  1  a committed board is available
- o_turn  output  1  committed side to move
- o_castle  output  4  committed castling rights
- o_ep  output  3  committed en-passant file
- o_hmcount  output  16  committed halfmove clock
- o_fmcount  output  16  committed fullmove number
- o_done  output  1  one-cycle pulse, frame committed
- o_error  output  1  one-cycle pulse, frame rejected
- o_busy  output  1  frame in progress, at least one square received

Behaviour:
- Reset, asynchronous, all outputs 0: board_valid, rd_data, metadata outputs, o_done, o_error, o_busy. State IDLE, square count 0, published bank select 0. Reset mid-frame discards the partial frame.
- Storage: two banks of 64 x 4 bits. Writes go to the shadow bank, reads come from the published bank.
- States: IDLE, LOAD, DRAIN.
- IDLE:
  - in_valid writes in_pdata to shadow[0]; count becomes 1; go to LOAD.
  - in_frame_end with no squares received: o_error pulse, stay IDLE.
- LOAD, on each in_valid:
  - Write shadow[count], then count+1.
  - Update king tallies: code 6 counts as a white king, code 14 as a black king. Tallies saturate at 2.
  - A code of 7, 8 or 15 sets a sticky bad flag.
  - in_valid arriving when count==SQUARES sets the bad flag and goes to DRAIN. The write is suppressed and the count does not wrap.
- DRAIN: all in_valid is ignored until in_frame_end.
- in_frame_end, evaluated after any same-cycle in_valid has been counted:
  - Commit when count==SQUARES, bad flag clear, and either CHECK_KINGS==0 or both king tallies ==1.
  - On commit, the next cycle: flip bank select, register in_turn/in_castle/in_ep/in_hmcount/in_fmcount onto the outputs, set board_valid=1, pulse o_done.
  - Otherwise, the next cycle: pulse o_error; published bank, metadata and board_valid are unchanged.
  - In every case: clear count, tallies and bad flag; return to IDLE.
- o_busy = 1 in LOAD and DRAIN.
- rd_data latency is 1 cycle: it reflects the published bank as of the cycle rd_addr is sampled. The cycle after o_done, reads already return the new bank.
- in_valid arriving in the cycle after in_frame_end starts a new frame normally; back-to-back frames need no gap.
- board_valid stays 1 after the first commit until reset.

Test Plan:
- Start position stream (r n b q k b n r, 8 pawns, 32 empty, 8 pawns, R N B Q K B N R), turn 0, castle 4'b1111, hm 0, fm 1, frame_end with the 64th square. Required: o_done 1 cycle later, board_valid=1, rd_addr 4 -> rd_data 14, rd_addr 60 -> 6, rd_addr 20 -> 0, o_castle=1111, o_fmcount=1.
- 63 squares then frame_end. Required: o_error pulse; board_valid and rd_data unchanged from the previous commit.
- 70 squares then frame_end. Required: o_error pulse; no write past square 63; o_busy stays 1 until frame_end.
- 64 squares with two white kings, CHECK_KINGS=1. Required: o_error. Same stream with CHECK_KINGS=0. Required: o_done.
- Frame A committed, frame B streamed while rd_addr=0 is held. Required: rd_data keeps A's code until the cycle after B's o_done, then shows B's code. A bad frame C (code 8 present) leaves B readable.
- rst asserted after 30 squares. Required: all outputs 0 immediately. A following full frame commits with o_done.

Source files
------------

// File: rtl/fen_board_loader_if.sv
// Bus between fen_decode, the double-buffered board loader and move generation.
// The master drives the square stream, frame metadata and read address.
interface fen_board_loader_if;
    logic        in_valid;
    logic [3:0]  in_pdata;
    logic        in_turn;
    logic [3:0]  in_castle;
    logic [2:0]  in_ep;
    logic [15:0] in_hmcount;
    logic [15:0] in_fmcount;
    logic        in_frame_end;
    logic [5:0]  rd_addr;
    logic [3:0]  rd_data;
    logic        board_valid;
    logic        o_turn;
    logic [3:0]  o_castle;
    logic [2:0]  o_ep;
    logic [15:0] o_hmcount;
    logic [15:0] o_fmcount;
    logic        o_done;
    logic        o_error;
    logic        o_busy;

    modport master (
        output in_valid, in_pdata, in_turn, in_castle, in_ep, in_hmcount, in_fmcount,
               in_frame_end, rd_addr,
        input  rd_data, board_valid, o_turn, o_castle, o_ep, o_hmcount, o_fmcount,
               o_done, o_error, o_busy
    );

    modport slave (
        input  in_valid, in_pdata, in_turn, in_castle, in_ep, in_hmcount, in_fmcount,
               in_frame_end, rd_addr,
        output rd_data, board_valid, o_turn, o_castle, o_ep, o_hmcount, o_fmcount,
               o_done, o_error, o_busy
    );
endinterface

// File: rtl/fen_board_loader.sv
// Assembles a validated FEN board into a shadow bank and publishes it atomically
// with its metadata; rejected frames leave the published bank untouched.
module fen_board_loader #(
    parameter int SQUARES     = 64,
    parameter int CHECK_KINGS = 1
) (
    input  logic               clk,
    input  logic               rst,
    fen_board_loader_if.slave  bus
);
    localparam int            CW   = $clog2(SQUARES + 1);
    localparam logic [CW-1:0] FULL = CW'(SQUARES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd2 : v + 2'd1;
    endfunction

    function automatic logic illegal_code(input logic [3:0] c);
        return (c == 4'd7) || (c == 4'd8) || (c == 4'd15);
    endfunction

    state_t        r_state, w_next_state;
    logic [CW-1:0] r_count, w_count;
    logic [1:0]    r_wk, r_bk, w_wk, w_bk;
    logic          r_bad, w_bad;
    logic          w_we, w_commit, w_reject;
    logic [5:0]    w_waddr;
    logic          r_bank_sel;
    logic [3:0]    r_mem [0:127];

    logic [3:0]    r_rd_data;
    logic          r_board_valid;
    logic          r_turn;
    logic [3:0]    r_castle;
    logic [2:0]    r_ep;
    logic [15:0]   r_hmcount;
    logic [15:0]   r_fmcount;
    logic          r_done;
    logic          r_error;
    logic          r_busy;

    assign w_waddr = 6'(r_count);

    // Square intake, frame validation and the commit/reject decision.
    always_comb begin
        w_next_state = r_state;
        w_count      = r_count;
        w_wk         = r_wk;
        w_bk         = r_bk;
        w_bad        = r_bad;
        w_we         = 1'b0;
        w_commit     = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            S_IDLE, S_LOAD: begin
                if (bus.in_valid) begin
                    if (r_count == FULL) begin
                        w_bad        = 1'b1;
                        w_next_state = S_DRAIN;
                    end else begin
                        w_we         = 1'b1;
                        w_count      = r_count + CW'(1);
                        w_next_state = S_LOAD;
                        if (bus.in_pdata == 4'd6) w_wk = sat_inc(r_wk);
                        else                      w_wk = r_wk;
                        if (bus.in_pdata == 4'd14) w_bk = sat_inc(r_bk);
                        else                       w_bk = r_bk;
                        if (illegal_code(bus.in_pdata)) w_bad = 1'b1;
                        else                            w_bad = r_bad;
                    end
                end else begin
                    w_next_state = r_state;
                end
            end
            S_DRAIN: begin
                w_next_state = S_DRAIN;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        // The end-of-frame verdict sees this cycle's square already counted.
        if (bus.in_frame_end) begin
            if ((w_count == FULL) && !w_bad &&
                ((CHECK_KINGS == 0) || ((w_wk == 2'd1) && (w_bk == 2'd1)))) begin
                w_commit = 1'b1;
            end else begin
                w_reject = 1'b1;
            end
            w_next_state = S_IDLE;
            w_count      = '0;
            w_wk         = 2'd0;
            w_bk         = 2'd0;
            w_bad        = 1'b0;
        end else begin
            w_commit = 1'b0;
        end
    end

    // Shadow-bank write port; the bank array carries no reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[{~r_bank_sel, w_waddr}] <= bus.in_pdata;
        end
    end

    // Frame state, publication registers and registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_wk          <= 2'd0;
            r_bk          <= 2'd0;
            r_bad         <= 1'b0;
            r_bank_sel    <= 1'b0;
            r_rd_data     <= 4'd0;
            r_board_valid <= 1'b0;
            r_turn        <= 1'b0;
            r_castle      <= 4'd0;
            r_ep          <= 3'd0;
            r_hmcount     <= 16'd0;
            r_fmcount     <= 16'd0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_count   <= w_count;
            r_wk      <= w_wk;
            r_bk      <= w_bk;
            r_bad     <= w_bad;
            r_done    <= w_commit;
            r_error   <= w_reject;
            r_busy    <= (w_next_state != S_IDLE);
            r_rd_data <= r_mem[{r_bank_sel, bus.rd_addr}];
            if (w_commit) begin
                r_bank_sel    <= ~r_bank_sel;
                r_board_valid <= 1'b1;
                r_turn        <= bus.in_turn;
                r_castle      <= bus.in_castle;
                r_ep          <= bus.in_ep;
                r_hmcount     <= bus.in_hmcount;
                r_fmcount     <= bus.in_fmcount;
            end
        end
    end

    assign bus.rd_data     = r_rd_data;
    assign bus.board_valid = r_board_valid;
    assign bus.o_turn      = r_turn;
    assign bus.o_castle    = r_castle;
    assign bus.o_ep        = r_ep;
    assign bus.o_hmcount   = r_hmcount;
    assign bus.o_fmcount   = r_fmcount;
    assign bus.o_done      = r_done;
    assign bus.o_error     = r_error;
    assign bus.o_busy      = r_busy;
endmodule

// File: tb/tb_fen_board_loader.sv
// Randomized self-checking bench: one loader with king checking, one without,
// both fed the same stream and compared against a frame-level board model.
module tb_fen_board_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        t_valid = 1'b0, t_fe = 1'b0, t_turn = 1'b0;
    logic [3:0]  t_pdata = 4'd0, t_castle = 4'd0;
    logic [2:0]  t_ep = 3'd0;
    logic [15:0] t_hm = 16'd0, t_fm = 16'd0;
    logic [5:0]  t_rd_addr = 6'd0;

    fen_board_loader_if bus_k();
    fen_board_loader_if bus_n();

    assign bus_k.in_valid = t_valid;     assign bus_n.in_valid = t_valid;
    assign bus_k.in_pdata = t_pdata;     assign bus_n.in_pdata = t_pdata;
    assign bus_k.in_turn = t_turn;       assign bus_n.in_turn = t_turn;
    assign bus_k.in_castle = t_castle;   assign bus_n.in_castle = t_castle;
    assign bus_k.in_ep = t_ep;           assign bus_n.in_ep = t_ep;
    assign bus_k.in_hmcount = t_hm;      assign bus_n.in_hmcount = t_hm;
    assign bus_k.in_fmcount = t_fm;      assign bus_n.in_fmcount = t_fm;
    assign bus_k.in_frame_end = t_fe;    assign bus_n.in_frame_end = t_fe;
    assign bus_k.rd_addr = t_rd_addr;    assign bus_n.rd_addr = t_rd_addr;

    fen_board_loader #(.SQUARES(64), .CHECK_KINGS(1)) dut_k (.clk(clk), .rst(rst), .bus(bus_k));
    fen_board_loader #(.SQUARES(64), .CHECK_KINGS(0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

    int total = 0;
    int bad   = 0;

    logic [3:0]  frame_q[$];
    bit          m_valid[2];
    logic [3:0]  m_board[2][64];
    logic        m_turn[2];
    logic [3:0]  m_castle[2];
    logic [2:0]  m_ep[2];
    logic [15:0] m_hm[2], m_fm[2];
    bit          exp_commit[2];

    logic        f_turn;
    logic [3:0]  f_castle;
    logic [2:0]  f_ep;
    logic [15:0] f_hm, f_fm;

    logic [3:0]  legal_codes[11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
    logic [3:0]  bad_codes[3]    = '{4'd7, 4'd8, 4'd15};
    logic [3:0]  start_pos[64];

    logic        s_done[2], s_err[2], s_bv[2], s_busy[2], s_turn[2];
    logic [3:0]  s_rd[2], s_castle[2];
    logic [2:0]  s_ep[2];
    logic [15:0] s_hm[2], s_fm[2];

    task automatic sample();
        s_done[0] = bus_k.o_done;        s_done[1] = bus_n.o_done;
        s_err[0] = bus_k.o_error;        s_err[1] = bus_n.o_error;
        s_bv[0] = bus_k.board_valid;     s_bv[1] = bus_n.board_valid;
        s_busy[0] = bus_k.o_busy;        s_busy[1] = bus_n.o_busy;
        s_turn[0] = bus_k.o_turn;        s_turn[1] = bus_n.o_turn;
        s_rd[0] = bus_k.rd_data;         s_rd[1] = bus_n.rd_data;
        s_castle[0] = bus_k.o_castle;    s_castle[1] = bus_n.o_castle;
        s_ep[0] = bus_k.o_ep;            s_ep[1] = bus_n.o_ep;
        s_hm[0] = bus_k.o_hmcount;       s_hm[1] = bus_n.o_hmcount;
        s_fm[0] = bus_k.o_fmcount;       s_fm[1] = bus_n.o_fmcount;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic junk_meta();
        t_turn   = 1'($urandom);
        t_castle = 4'($urandom);
        t_ep     = 3'($urandom);
        t_hm     = 16'($urandom);
        t_fm     = 16'($urandom);
    endtask

    task automatic rand_meta();
        f_turn   = 1'($urandom);
        f_castle = 4'($urandom);
        f_ep     = 3'($urandom);
        f_hm     = 16'($urandom);
        f_fm     = 16'($urandom);
    endtask

    task automatic put_meta();
        t_turn = f_turn; t_castle = f_castle; t_ep = f_ep; t_hm = f_hm; t_fm = f_fm;
    endtask

    // Reference: a frame commits iff exactly 64 squares, none illegal, and
    // (when kings are checked) exactly one king of each colour.
    task automatic model_frame(input int inst);
        bit ok;
        int wk, bk;
        ok = (frame_q.size() == 64);
        wk = 0;
        bk = 0;
        for (int i = 0; i < frame_q.size() && i < 64; i++) begin
            if (frame_q[i] == 4'd6)  wk++;
            if (frame_q[i] == 4'd14) bk++;
            if (frame_q[i] == 4'd7 || frame_q[i] == 4'd8 || frame_q[i] == 4'd15) ok = 1'b0;
        end
        if (inst == 0 && (wk != 1 || bk != 1)) ok = 1'b0;
        exp_commit[inst] = ok;
        if (ok) begin
            m_valid[inst] = 1'b1;
            for (int j = 0; j < 64; j++) m_board[inst][j] = frame_q[j];
            m_turn[inst] = f_turn; m_castle[inst] = f_castle; m_ep[inst] = f_ep;
            m_hm[inst] = f_hm;     m_fm[inst] = f_fm;
        end
    endtask

    task automatic gen_frame(input int kind);
        int wk_pos, bk_pos;
        frame_q.delete();
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 1) == 0) frame_q.push_back(4'd0);
            else frame_q.push_back(legal_codes[$urandom_range(0, 10)]);
        end
        wk_pos = $urandom_range(11, 31);
        bk_pos = $urandom_range(32, 63);
        frame_q[wk_pos] = 4'd6;
        frame_q[bk_pos] = 4'd14;
        case (kind)
            1: void'(frame_q.pop_back());
            2: repeat ($urandom_range(1, 8)) frame_q.push_back(4'($urandom));
            3: frame_q[$urandom_range(0, 63)] = bad_codes[$urandom_range(0, 2)];
            4: frame_q[$urandom_range(0, 10)] = 4'd6;
            5: frame_q[bk_pos] = 4'd0;
            default: ;
        endcase
    endtask

    // Streams frame_q; rd_addr is left as the caller set it so reads of the
    // published board are checked on every cycle of the frame.
    task automatic send_frame(input bit fe_with_last);
        int n;
        bit last;
        n = frame_q.size();
        for (int i = 0; i < n; i++) begin
            last = fe_with_last && (i == n - 1);
            t_valid = 1'b1;
            t_pdata = frame_q[i];
            junk_meta();
            t_fe = last;
            if (last) put_meta();
            tick();
            for (int k = 0; k < 2; k++) begin
                if (!last) begin
                    total++;
                    if (s_busy[k] !== 1'b1) begin
                        bad++;
                        $display("FAIL busy inst%0d sq%0d got=%b exp=1", k, i, s_busy[k]);
                    end
                end
                if (m_valid[k]) begin
                    total++;
                    if (s_rd[k] !== m_board[k][t_rd_addr]) begin
                        bad++;
                        $display("FAIL hold_rd inst%0d sq%0d addr=%0d got=%0d exp=%0d", k, i, t_rd_addr, s_rd[k], m_board[k][t_rd_addr]);
                    end
                end
            end
        end
        if (!fe_with_last || n == 0) begin
            t_valid = 1'b0;
            t_fe = 1'b1;
            put_meta();
            tick();
        end
        t_valid = 1'b0;
        t_fe = 1'b0;
        junk_meta();
        for (int k = 0; k < 2; k++) begin
            model_frame(k);
            total++;
            if (s_done[k] !== exp_commit[k] || s_err[k] !== !exp_commit[k] || s_busy[k] !== 1'b0) begin
                bad++;
                $display("FAIL frame_result inst%0d got done=%b err=%b busy=%b exp done=%b err=%b busy=0",
                         k, s_done[k], s_err[k], s_busy[k], exp_commit[k], !exp_commit[k]);
            end
            total++;
            if (s_bv[k] !== m_valid[k]) begin
                bad++;
                $display("FAIL board_valid inst%0d got=%b exp=%b", k, s_bv[k], m_valid[k]);
            end
            if (m_valid[k]) begin
                total++;
                if ({s_turn[k], s_castle[k], s_ep[k], s_hm[k], s_fm[k]} !==
                    {m_turn[k], m_castle[k], m_ep[k], m_hm[k], m_fm[k]}) begin
                    bad++;
                    $display("FAIL meta inst%0d got=%h exp=%h", k,
                             {s_turn[k], s_castle[k], s_ep[k], s_hm[k], s_fm[k]},
                             {m_turn[k], m_castle[k], m_ep[k], m_hm[k], m_fm[k]});
                end
            end
        end
    endtask

    task automatic test_readback();
        for (int a = 0; a < 64; a++) begin
            t_rd_addr = 6'(a);
            tick();
            for (int k = 0; k < 2; k++) begin
                if (m_valid[k]) begin
                    total++;
                    if (s_rd[k] !== m_board[k][a]) begin
                        bad++;
                        $display("FAIL readback inst%0d addr=%0d got=%0d exp=%0d", k, a, s_rd[k], m_board[k][a]);
                    end
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({s_rd[k], s_done[k], s_err[k], s_bv[k], s_busy[k], s_turn[k], s_castle[k], s_ep[k], s_hm[k], s_fm[k]} !== 49'd0) begin
                bad++;
                $display("FAIL %s inst%0d outputs got=%h exp=0", tag, k,
                         {s_rd[k], s_done[k], s_err[k], s_bv[k], s_busy[k], s_turn[k], s_castle[k], s_ep[k], s_hm[k], s_fm[k]});
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1 sample();
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) m_valid[k] = 1'b0;
    endtask

    task automatic test_empty_end();
        frame_q.delete();
        rand_meta();
        send_frame(1'b1);
    endtask

    task automatic test_start_pos();
        int addrs[3] = '{4, 60, 20};
        logic [3:0] want[3] = '{4'd14, 4'd6, 4'd0};
        frame_q.delete();
        for (int i = 0; i < 64; i++) frame_q.push_back(start_pos[i]);
        f_turn = 1'b0; f_castle = 4'b1111; f_ep = 3'd0; f_hm = 16'd0; f_fm = 16'd1;
        send_frame(1'b1);
        total++;
        if (s_done[0] !== 1'b1 || s_bv[0] !== 1'b1 || s_castle[0] !== 4'b1111 || s_fm[0] !== 16'd1) begin
            bad++;
            $display("FAIL start_pos got done=%b bv=%b castle=%b fm=%0d exp 1 1 1111 1", s_done[0], s_bv[0], s_castle[0], s_fm[0]);
        end
        for (int j = 0; j < 3; j++) begin
            t_rd_addr = 6'(addrs[j]);
            tick();
            total++;
            if (s_rd[0] !== want[j]) begin
                bad++;
                $display("FAIL start_rd addr=%0d got=%0d exp=%0d", addrs[j], s_rd[0], want[j]);
            end
        end
    endtask

    task automatic test_short();
        gen_frame(1);
        rand_meta();
        send_frame(1'b1);
        total++;
        if (s_err[0] !== 1'b1 || s_bv[0] !== 1'b1) begin
            bad++;
            $display("FAIL short_frame got err=%b bv=%b exp err=1 bv=1", s_err[0], s_bv[0]);
        end
    endtask

    task automatic test_overflow();
        gen_frame(0);
        while (frame_q.size() < 70) frame_q.push_back(4'($urandom));
        rand_meta();
        send_frame(1'b0);
        total++;
        if (s_err[1] !== 1'b1) begin
            bad++;
            $display("FAIL overflow got err=%b exp=1", s_err[1]);
        end
    endtask

    task automatic test_two_kings();
        gen_frame(0);
        frame_q[0] = 4'd6;
        rand_meta();
        send_frame(1'b1);
        total++;
        if (s_err[0] !== 1'b1 || s_done[1] !== 1'b1) begin
            bad++;
            $display("FAIL two_kings got chk_err=%b nochk_done=%b exp 1 1", s_err[0], s_done[1]);
        end
    endtask

    task automatic test_rd_hold();
        t_rd_addr = 6'd0;
        gen_frame(0);
        frame_q[0] = 4'd12;
        rand_meta();
        send_frame(1'b1);
        tick();
        gen_frame(0);
        frame_q[0] = 4'd2;
        rand_meta();
        send_frame(1'b1);
        total++;
        if (s_done[0] !== 1'b1 || s_rd[0] !== 4'd12) begin
            bad++;
            $display("FAIL hold_old got done=%b rd=%0d exp done=1 rd=12", s_done[0], s_rd[0]);
        end
        tick();
        total++;
        if (s_rd[0] !== 4'd2) begin
            bad++;
            $display("FAIL hold_new got rd=%0d exp=2", s_rd[0]);
        end
        gen_frame(0);
        frame_q[10] = 4'd8;
        rand_meta();
        send_frame(1'b1);
        tick();
        total++;
        if (s_err[1] !== 1'b0 || s_rd[0] !== 4'd2 || s_rd[1] !== 4'd2) begin
            bad++;
            $display("FAIL bad_frame_keep got rd=%0d/%0d exp 2/2", s_rd[0], s_rd[1]);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 24; f++) begin
            t_rd_addr = 6'($urandom);
            gen_frame(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0);
            rand_meta();
            send_frame(1'($urandom));
            if (f % 8 == 7) test_readback();
        end
    endtask

    task automatic test_reset_mid();
        gen_frame(0);
        for (int i = 0; i < 30; i++) begin
            t_valid = 1'b1;
            t_pdata = frame_q[i];
            tick();
        end
        rst = 1'b1;
        #1 sample();
        check_all_zero("mid_reset");
        t_valid = 1'b0;
        for (int k = 0; k < 2; k++) m_valid[k] = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        gen_frame(0);
        rand_meta();
        send_frame(1'b1);
        total++;
        if (s_done[0] !== 1'b1 || s_bv[0] !== 1'b1) begin
            bad++;
            $display("FAIL after_reset got done=%b bv=%b exp 1 1", s_done[0], s_bv[0]);
        end
        test_readback();
    endtask

    initial begin
        start_pos = '{4'd12, 4'd10, 4'd11, 4'd13, 4'd14, 4'd11, 4'd10, 4'd12,
                      4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9,
                      4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                      4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                      4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                      4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                      4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1,
                      4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
        test_reset();
        test_empty_end();
        test_start_pos();
        test_readback();
        test_short();
        test_readback();
        test_overflow();
        test_two_kings();
        test_readback();
        test_rd_hold();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
